// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID-stage instruction fields, branch/memory status
// in; pipeline enables, flush/bubble, forwarding selects and stall count out.
interface pipe_hazard_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [ADDR_W-1:0] id_rd;
  logic              id_rw;
  logic              id_memr;
  logic              br_taken;
  logic              mem_busy;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rw, id_memr, br_taken, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rw, id_memr, br_taken, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding select and stall/flush control for a 5-stage
// in-order pipeline. Shadows the EX/MEM/WB destination info it needs.
module pipe_hazard_ctrl #(
  parameter int ADDR_W = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);

  logic              ex_valid, ex_rw, ex_memr, ex_rs1_used, ex_rs2_used;
  logic [ADDR_W-1:0] ex_rd, ex_rs1, ex_rs2;
  logic              mem_valid, mem_rw, mem_memr;
  logic [ADDR_W-1:0] mem_rd;
  logic              wb_valid, wb_rw;
  logic [ADDR_W-1:0] wb_rd;

  logic ex_hit, mem_hit, hazard;

  function automatic logic match(input logic v, input logic rw, input logic used,
                                 input logic [ADDR_W-1:0] rd,
                                 input logic [ADDR_W-1:0] src);
    return v & rw & used & (rd == src);
  endfunction

  // ID source dependencies on older in-flight writers
  always_comb begin
    ex_hit  = match(ex_valid, ex_rw, hz.id_rs1_used, ex_rd, hz.id_rs1) |
              match(ex_valid, ex_rw, hz.id_rs2_used, ex_rd, hz.id_rs2);
    mem_hit = match(mem_valid, mem_rw, hz.id_rs1_used, mem_rd, hz.id_rs1) |
              match(mem_valid, mem_rw, hz.id_rs2_used, mem_rd, hz.id_rs2);
    hazard  = 1'b0;
    if (FWD_EN != 0) hazard = hz.id_valid & ex_memr & ex_hit;
    else             hazard = hz.id_valid & (ex_hit | mem_hit);
  end

  // Pipeline control: freeze beats flush, flush beats hazard stall
  always_comb begin
    hz.pc_en       = 1'b1;
    hz.ifid_en     = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;
    if (rst) begin
      if (hz.mem_busy) begin
        hz.pc_en   = 1'b0;
        hz.ifid_en = 1'b0;
      end else if (hz.br_taken && ex_valid) begin
        hz.ifid_flush  = 1'b1;
        hz.idex_bubble = 1'b1;
      end else if (hazard) begin
        hz.pc_en       = 1'b0;
        hz.ifid_en     = 1'b0;
        hz.idex_bubble = 1'b1;
      end
    end
  end

  // EX operand forwarding: EX/MEM result preferred over MEM/WB
  always_comb begin
    hz.fwd_a = 2'b00;
    hz.fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (match(mem_valid, mem_rw, ex_rs1_used, mem_rd, ex_rs1) && !mem_memr)
        hz.fwd_a = 2'b01;
      else if (match(wb_valid, wb_rw, ex_rs1_used, wb_rd, ex_rs1))
        hz.fwd_a = 2'b10;
      if (match(mem_valid, mem_rw, ex_rs2_used, mem_rd, ex_rs2) && !mem_memr)
        hz.fwd_b = 2'b01;
      else if (match(wb_valid, wb_rw, ex_rs2_used, wb_rd, ex_rs2))
        hz.fwd_b = 2'b10;
    end
  end

  // Stage shadow registers advance unless memory is busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ex_rw       <= 1'b0;
      ex_memr     <= 1'b0;
      ex_rs1_used <= 1'b0;
      ex_rs2_used <= 1'b0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      mem_valid   <= 1'b0;
      mem_rw      <= 1'b0;
      mem_memr    <= 1'b0;
      mem_rd      <= '0;
      wb_valid    <= 1'b0;
      wb_rw       <= 1'b0;
      wb_rd       <= '0;
    end else if (!hz.mem_busy) begin
      wb_valid    <= mem_valid;
      wb_rw       <= mem_rw;
      wb_rd       <= mem_rd;
      mem_valid   <= ex_valid;
      mem_rw      <= ex_rw;
      mem_memr    <= ex_memr;
      mem_rd      <= ex_rd;
      ex_valid    <= hz.id_valid & ~hz.idex_bubble;
      ex_rw       <= hz.id_rw;
      ex_memr     <= hz.id_memr;
      ex_rs1_used <= hz.id_rs1_used;
      ex_rs2_used <= hz.id_rs2_used;
      ex_rd       <= hz.id_rd;
      ex_rs1      <= hz.id_rs1;
      ex_rs2      <= hz.id_rs2;
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hz.stall_cnt <= '0;
    else if (!hz.pc_en && hz.stall_cnt != '1)
      hz.stall_cnt <= hz.stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (forwarding, stall-only,
// 4-bit counter) share one stimulus stream and are compared each cycle
// against a per-instance behavioural model, plus directed scenario checks.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       rw;
    logic       memr;
    logic [2:0] rs1;
    logic       u1;
    logic [2:0] rs2;
    logic       u2;
  } ins_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.ADDR_W(3), .CNT_W(16)) if_f ();
  pipe_hazard_ctrl_if #(.ADDR_W(3), .CNT_W(16)) if_s ();
  pipe_hazard_ctrl_if #(.ADDR_W(3), .CNT_W(4))  if_c ();

  pipe_hazard_ctrl #(.ADDR_W(3), .FWD_EN(1), .CNT_W(16)) dut_f (.clk(clk), .rst(rst), .hz(if_f.slave));
  pipe_hazard_ctrl #(.ADDR_W(3), .FWD_EN(0), .CNT_W(16)) dut_s (.clk(clk), .rst(rst), .hz(if_s.slave));
  pipe_hazard_ctrl #(.ADDR_W(3), .FWD_EN(1), .CNT_W(4))  dut_c (.clk(clk), .rst(rst), .hz(if_c.slave));

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  ins_t cur;
  logic br, busy;

  // model state per instance: [0]=EX [1]=MEM [2]=WB
  ins_t        pipe [3][3];
  int unsigned cnt  [3];
  int unsigned cmax [3] = '{65535, 65535, 15};
  bit          fwdm [3] = '{1'b1, 1'b0, 1'b1};
  bit          e_pc [3];
  bit          e_bb [3];
  string       nm   [3] = '{"fwd", "stl", "sat"};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(input logic v, input int rd, input logic rw, input logic memr,
                              input int rs1, input logic u1, input int rs2, input logic u2);
    ins_t i;
    i.v = v; i.rd = 3'(rd); i.rw = rw; i.memr = memr;
    i.rs1 = 3'(rs1); i.u1 = u1; i.rs2 = 3'(rs2); i.u2 = u2;
    return i;
  endfunction

  function automatic bit writes_to(input ins_t p, input logic [2:0] r, input logic used);
    return p.v && p.rw && used && (p.rd == r);
  endfunction

  task automatic drive();
    if_f.id_valid = cur.v;    if_s.id_valid = cur.v;    if_c.id_valid = cur.v;
    if_f.id_rs1 = cur.rs1;    if_s.id_rs1 = cur.rs1;    if_c.id_rs1 = cur.rs1;
    if_f.id_rs2 = cur.rs2;    if_s.id_rs2 = cur.rs2;    if_c.id_rs2 = cur.rs2;
    if_f.id_rs1_used = cur.u1; if_s.id_rs1_used = cur.u1; if_c.id_rs1_used = cur.u1;
    if_f.id_rs2_used = cur.u2; if_s.id_rs2_used = cur.u2; if_c.id_rs2_used = cur.u2;
    if_f.id_rd = cur.rd;      if_s.id_rd = cur.rd;      if_c.id_rd = cur.rd;
    if_f.id_rw = cur.rw;      if_s.id_rw = cur.rw;      if_c.id_rw = cur.rw;
    if_f.id_memr = cur.memr;  if_s.id_memr = cur.memr;  if_c.id_memr = cur.memr;
    if_f.br_taken = br;       if_s.br_taken = br;       if_c.br_taken = br;
    if_f.mem_busy = busy;     if_s.mem_busy = busy;     if_c.mem_busy = busy;
  endtask

  task automatic get(input int m, output logic pc, output logic ie, output logic fl,
                     output logic bb, output logic [1:0] fa, output logic [1:0] fb,
                     output logic [15:0] sc);
    case (m)
      0: begin pc = if_f.pc_en; ie = if_f.ifid_en; fl = if_f.ifid_flush; bb = if_f.idex_bubble;
               fa = if_f.fwd_a; fb = if_f.fwd_b; sc = if_f.stall_cnt; end
      1: begin pc = if_s.pc_en; ie = if_s.ifid_en; fl = if_s.ifid_flush; bb = if_s.idex_bubble;
               fa = if_s.fwd_a; fb = if_s.fwd_b; sc = if_s.stall_cnt; end
      default: begin pc = if_c.pc_en; ie = if_c.ifid_en; fl = if_c.ifid_flush; bb = if_c.idex_bubble;
               fa = if_c.fwd_a; fb = if_c.fwd_b; sc = 16'(if_c.stall_cnt); end
    endcase
  endtask

  function automatic logic [1:0] fwd_src(input int m, input logic [2:0] r, input logic used);
    if (!fwdm[m]) return 2'b00;
    if (writes_to(pipe[m][1], r, used) && !pipe[m][1].memr) return 2'b01;
    if (writes_to(pipe[m][2], r, used)) return 2'b10;
    return 2'b00;
  endfunction

  // Behavioural expectation for instance m given current inputs and model state
  task automatic expect_ctrl(input int m, output bit pc, output bit fl, output bit bb,
                             output logic [1:0] fa, output logic [1:0] fb);
    bit haz = 0;
    int depth = fwdm[m] ? 1 : 2;
    for (int d = 0; d < depth; d++) begin
      if (fwdm[m] && !pipe[m][d].memr) continue;
      if (cur.v && (writes_to(pipe[m][d], cur.rs1, cur.u1) || writes_to(pipe[m][d], cur.rs2, cur.u2)))
        haz = 1;
    end
    pc = 1; fl = 0; bb = 0;
    if (rst) begin
      if (busy) pc = 0;
      else if (br && pipe[m][0].v) begin fl = 1; bb = 1; end
      else if (haz) begin pc = 0; bb = 1; end
    end
    fa = fwd_src(m, pipe[m][0].rs1, pipe[m][0].u1);
    fb = fwd_src(m, pipe[m][0].rs2, pipe[m][0].u2);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      cnt[m] = 0;
      for (int d = 0; d < 3; d++) pipe[m][d] = '0;
    end
  endtask

  // Called at a negedge with inputs set; checks, crosses posedge, returns at negedge
  task automatic cycle();
    bit pc, fl, bb;
    logic [1:0] fa, fb, gfa, gfb;
    logic gpc, gie, gfl, gbb;
    logic [15:0] gsc;
    drive();
    #1;
    for (int m = 0; m < 3; m++) begin
      expect_ctrl(m, pc, fl, bb, fa, fb);
      get(m, gpc, gie, gfl, gbb, gfa, gfb, gsc);
      check({nm[m], " pc_en"}, 32'(gpc), 32'(pc));
      check({nm[m], " ifid_en"}, 32'(gie), 32'(pc));
      check({nm[m], " ifid_flush"}, 32'(gfl), 32'(fl));
      check({nm[m], " idex_bubble"}, 32'(gbb), 32'(bb));
      check({nm[m], " fwd_a"}, 32'(gfa), 32'(fa));
      check({nm[m], " fwd_b"}, 32'(gfb), 32'(fb));
      check({nm[m], " stall_cnt"}, 32'(gsc), cnt[m]);
      e_pc[m] = pc;
      e_bb[m] = bb;
    end
    @(posedge clk);
    if (rst) begin
      for (int m = 0; m < 3; m++) begin
        if (!e_pc[m] && cnt[m] < cmax[m]) cnt[m]++;
        if (!busy) begin
          pipe[m][2] = pipe[m][1];
          pipe[m][1] = pipe[m][0];
          pipe[m][0] = cur;
          pipe[m][0].v = cur.v && !e_bb[m];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    cycle();
    rst = 1'b1;
  endtask

  localparam int LD = 0, ADD = 1;
  ins_t nop;

  initial begin
    nop = '0;
    cur = '0; br = 0; busy = 0; rst = 1'b0;
    model_reset();
    drive();
    @(negedge clk);
    do_reset();

    // load r2 ; add r3 = r2 + r1 (load-use, one stall, then WB forward)
    cur = mk(1, 2, 1, 1, 0, 0, 0, 0); cycle();
    cur = mk(1, 3, 1, 0, 2, 1, 1, 1); drive(); #1;
    check("lu pc_en", 32'(if_f.pc_en), 0);
    check("lu bubble", 32'(if_f.idex_bubble), 1);
    cycle();
    #1; check("lu resume", 32'(if_f.pc_en), 1);
    cycle();
    cur = nop; drive(); #1;
    check("lu fwd_a", 32'(if_f.fwd_a), 32'(2'b10));
    check("lu cnt", 32'(if_f.stall_cnt), 1);
    cycle();

    // ALU r4 ; two consumers of r4 on rs2 (EX/MEM then MEM/WB forward)
    do_reset();
    cur = mk(1, 4, 1, 0, 0, 0, 0, 0); cycle();
    cur = mk(1, 7, 1, 0, 1, 1, 4, 1); drive(); #1;
    check("alu nostall", 32'(if_f.pc_en), 1);
    cycle();
    cur = mk(1, 6, 0, 0, 0, 0, 4, 1); drive(); #1;
    check("alu fwd_b 01", 32'(if_f.fwd_b), 32'(2'b01));
    cycle();
    cur = nop; drive(); #1;
    check("alu fwd_b 10", 32'(if_f.fwd_b), 32'(2'b10));
    cycle();

    // stall-only mode: ALU r5 ; use r5 -> two stalls
    do_reset();
    cur = mk(1, 5, 1, 0, 0, 0, 0, 0); cycle();
    cur = mk(1, 1, 1, 0, 5, 1, 0, 0); drive(); #1;
    check("so stall1", 32'(if_s.pc_en), 0);
    cycle(); #1;
    check("so stall2", 32'(if_s.pc_en), 0);
    cycle(); #1;
    check("so go", 32'(if_s.pc_en), 1);
    cycle();
    cur = nop; drive(); #1;
    check("so fwd_a", 32'(if_s.fwd_a), 0);
    check("so cnt", 32'(if_s.stall_cnt), 2);
    cycle();

    // load-use together with a taken branch: flush wins, no stall counted
    do_reset();
    cur = mk(1, 2, 1, 1, 0, 0, 0, 0); cycle();
    cur = mk(1, 3, 1, 0, 2, 1, 0, 0); br = 1; drive(); #1;
    check("br flush", 32'(if_f.ifid_flush), 1);
    check("br bubble", 32'(if_f.idex_bubble), 1);
    check("br pc_en", 32'(if_f.pc_en), 1);
    cycle();
    br = 0; cur = nop; drive(); #1;
    check("br cnt", 32'(if_f.stall_cnt), 0);
    cycle();

    // memory busy for 3 cycles with a pending load-use
    do_reset();
    cur = mk(1, 2, 1, 1, 0, 0, 0, 0); cycle();
    cur = mk(1, 3, 1, 0, 0, 0, 2, 1); busy = 1;
    for (int i = 0; i < 3; i++) begin
      drive(); #1;
      check("busy pc_en", 32'(if_f.pc_en), 0);
      check("busy bubble", 32'(if_f.idex_bubble), 0);
      cycle();
    end
    busy = 0; drive(); #1;
    check("post-busy stall", 32'(if_f.idex_bubble), 1);
    cycle(); #1;
    check("busy cnt", 32'(if_f.stall_cnt), 4);
    cycle();

    // counter saturation on the 4-bit instance
    do_reset();
    cur = nop; busy = 1;
    for (int i = 0; i < 20; i++) cycle();
    busy = 0; drive(); #1;
    check("sat cnt", 32'(if_c.stall_cnt), 15);
    check("wide cnt", 32'(if_f.stall_cnt), 20);
    cycle();

    // asynchronous reset in the middle of a load-use stall
    do_reset();
    cur = mk(1, 2, 1, 1, 0, 0, 0, 0); cycle();
    cur = mk(1, 3, 1, 0, 2, 1, 0, 0); drive(); #1;
    check("pre-rst stall", 32'(if_f.pc_en), 0);
    rst = 1'b0; model_reset(); #1;
    check("rst pc_en", 32'(if_f.pc_en), 1);
    check("rst bubble", 32'(if_f.idex_bubble), 0);
    check("rst cnt", 32'(if_f.stall_cnt), 0);
    cycle();
    rst = 1'b1; drive(); #1;
    check("post-rst nostall", 32'(if_f.pc_en), 1);
    cycle();

    // randomized traffic over a small register set
    for (int i = 0; i < 600; i++) begin
      cur = mk(($urandom_range(7) != 0), $urandom_range(3), $urandom_range(1),
               ($urandom_range(2) == 0), $urandom_range(3), $urandom_range(1),
               $urandom_range(3), $urandom_range(1));
      br   = ($urandom_range(5) == 0);
      busy = ($urandom_range(4) == 0);
      if ($urandom_range(99) == 0) do_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 3: register-address width.
REQ-002 SHALL have parameter FWD_EN, default 1: 1 = forwarding mode, 0 = stall-only mode.
REQ-003 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 id_valid  in  1  ID stage holds a real instruction.
REQ-007 id_rs1, id_rs2  in  ADDR_W each  ID source-register addresses.
REQ-008 id_rs1_used, id_rs2_used  in  1 each  the ID instruction reads that source.
REQ-009 id_rd  in  ADDR_W  ID destination address.
REQ-010 id_rw, id_memr  in  1 each  ID writes the register file; ID is a load.
REQ-011 br_taken  in  1  instruction in EX redirects the PC.
REQ-012 mem_busy  in  1  data memory not ready; the whole pipe freezes.
REQ-013 pc_en, ifid_en  out  1 each  PC and IF/ID register load enables.
REQ-014 ifid_flush  out  1  clear IF/ID to a NOP.
REQ-015 idex_bubble  out  1  load a NOP into ID/EX.
REQ-016 fwd_a, fwd_b  out  2 each  EX operand source: 00 register file, 01 EX/MEM, 10 MEM/WB.
REQ-017 stall_cnt  out  CNT_W  count of stall cycles.

Function
REQ-018 SHALL track EX, MEM and WB stages internally; each holds valid, rd, rw and memr; EX also holds rs1, rs2, rs1_used, rs2_used.
REQ-019 Advance (mem_busy=0): WB<=MEM, MEM<=EX; EX<=ID fields with valid=id_valid, except valid=0 when idex_bubble=1.
REQ-020 Freeze (mem_busy=1): no internal state changes; pc_en=ifid_en=0, ifid_flush=idex_bubble=0; stall_cnt still increments.
REQ-021 Match (stage S, source x): S.valid & S.rw & x_used & S.rd==x.
REQ-022 FWD_EN=1 hazard: ID match against an EX stage with memr=1 (load-use); stall exactly 1 cycle.
REQ-023 FWD_EN=0 hazard: ID match against EX or MEM; WB match does not stall, because the register file writes before it is read.
REQ-024 Stall (hazard, mem_busy=0, br_taken=0): pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0.
REQ-025 Flush (br_taken=1 and EX.valid=1, mem_busy=0): ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1; this overrides any hazard stall.
REQ-026 br_taken with EX.valid=0 SHALL be ignored; br_taken during mem_busy is ignored, and the source holds br_taken until mem_busy drops.
REQ-027 Otherwise: pc_en=ifid_en=1, ifid_flush=idex_bubble=0.
REQ-028 Control outputs SHALL be combinational from the current inputs and stage state.
REQ-029 fwd_a (FWD_EN=1), for EX rs1: 01 if MEM matches and MEM.memr=0; otherwise 10 if WB matches; otherwise 00. fwd_b is the same for rs2.
REQ-030 EX/MEM SHALL take priority over MEM/WB.
REQ-031 FWD_EN=0: fwd_a=fwd_b=00 always.
REQ-032 stall_cnt increments by 1 on each edge where pc_en=0, and saturates at all-ones.
REQ-033 A flush cycle SHALL NOT count as a stall.

Reset
REQ-034 While rst=0: all stage valid bits=0, stall_cnt=0, fwd_a=fwd_b=00, pc_en=ifid_en=1, ifid_flush=idex_bubble=0.
REQ-035 Reset asserted mid-stall or mid-flush SHALL abandon the operation immediately.
REQ-036 The first edge after reset release SHALL behave as a normal advance.

Verification
REQ-037 Bench SHALL cover these scenarios (FWD_EN=1 unless stated):
- Load r2 then add r3=r2+r1 back-to-back -> one cycle pc_en=0, idex_bubble=1; next EX cycle fwd_a=10; stall_cnt=1.
- ALU write r4 then use r4 as rs2 -> no stall; fwd_b=01; a cycle later the dependent instruction in MEM/WB-distance position gets fwd_b=10.
- FWD_EN=0, ALU write r5 then use r5 -> 2 stall cycles, then proceeds with fwd=00; stall_cnt=2.
- Load-use hazard and br_taken=1 in same cycle -> ifid_flush=1, idex_bubble=1, pc_en=1; stall_cnt unchanged.
- mem_busy=1 for 3 cycles with a load-use hazard pending -> state frozen, stall_cnt+=3; the hazard stall occurs after release.
- stall_cnt preloaded near max via 2^CNT_W stalls (CNT_W=4) -> holds at 15.
- rst driven low mid-stall -> outputs return to reset values asynchronously; the first instruction after release suffers no spurious stall.
